// File: rtl/text_writer.sv
// -----------------------------------------------------------------------------
// text_writer
//
// Writer side of the 4x16 character screen buffer. ASCII bytes arrive over a
// valid/ready stream. The block handles a few terminal control codes (LF, CR
// and BS) and keeps the cursor and scroll state. The text engine fetches
// characters through an asynchronous read port, indexed by a 6-bit cell
// address {row[1:0], col[3:0]}.
//
// Optional feature macro: TEXT_WRITER_CURSOR_EN
//   When it is defined, a free-running BLINK_BITS-wide counter is built. While
//   the counter MSB is set and the block is idle, reads of the cursor cell
//   return '_' (0x5F). The buffer contents themselves are not changed.
//
// Parameters (only when TEXT_WRITER_CURSOR_EN is defined)
//   BLINK_BITS     width of the cursor blink counter
//
// Ports
//   clk_i          system clock
//   reset_ni       asynchronous active-low reset
//   char_valid_i   input byte valid
//   char_i         input byte
//   char_ready_o   high when a byte can be accepted this cycle
//   clear_i        request to blank the screen and home the cursor
//   readAddress_i  character cell index {row, col}
//   outByte_o      character stored at readAddress_i
//   cursor_o       current cursor cell {row, col}
//   busy_o         high while a CLEAR or SCROLL sequence is running
// -----------------------------------------------------------------------------
module text_writer
`ifdef TEXT_WRITER_CURSOR_EN
  #(parameter int BLINK_BITS = 24)
`endif
(
  input  logic       clk_i,
  input  logic       reset_ni,
  input  logic       char_valid_i,
  input  logic [7:0] char_i,
  output logic       char_ready_o,
  input  logic       clear_i,
  input  logic [5:0] readAddress_i,
  output logic [7:0] outByte_o,
  output logic [5:0] cursor_o,
  output logic       busy_o
);

  typedef enum logic [1:0] {
    StIdle,
    StClear,
    StScroll
  } state_t;

  localparam logic [7:0] Space     = 8'h20;
  localparam logic [7:0] LineFeed  = 8'h0A;
  localparam logic [7:0] CarReturn = 8'h0D;
  localparam logic [7:0] BackSpace = 8'h08;

  state_t     state;
  logic [5:0] k;
  logic [1:0] row;
  logic [3:0] col;
  logic [7:0] screenBuf [64];

  logic       memWe;
  logic [5:0] memAddr;
  logic [7:0] memData;
  logic [5:0] scrollSrcAddr;
  logic       byteTaken;
  logic       isPrintable;
  logic [7:0] rawByte;

  assign byteTaken     = (state == StIdle) && !clear_i && char_valid_i;
  assign isPrintable   = (char_i >= 8'h20) && (char_i <= 8'h7E);
  assign scrollSrcAddr = k + 6'd16;

  assign char_ready_o = (state == StIdle) && !clear_i;
  assign busy_o       = (state != StIdle);
  assign cursor_o     = {row, col};
  assign rawByte      = screenBuf[readAddress_i];

  // Pick the single buffer write for this cycle. CLEAR blanks cell k. SCROLL
  // copies cell k from the row below it, or blanks cell k on the last row.
  // In IDLE, a printable byte lands at the cursor. A backspace that is not at
  // column 0 blanks the cell to the left of the cursor, which is where the
  // cursor moves to.
  always_comb begin
    memWe   = 1'b0;
    memAddr = k;
    memData = Space;
    case (state)
      StClear: begin
        memWe = 1'b1;
      end
      StScroll: begin
        memWe = 1'b1;
        if (k < 6'd48) begin
          memData = screenBuf[scrollSrcAddr];
        end
      end
      default: begin
        if (byteTaken) begin
          if (isPrintable) begin
            memWe   = 1'b1;
            memAddr = {row, col};
            memData = char_i;
          end else if ((char_i == BackSpace) && (col != 4'd0)) begin
            memWe   = 1'b1;
            memAddr = {row, col - 4'd1};
          end
        end
      end
    endcase
  end

  // Main sequencer and buffer storage. Reset drops straight into CLEAR with
  // k = 0, so any CLEAR or SCROLL in progress is aborted and restarted as a
  // full blank. The buffer lives in this block so that nothing is written
  // while reset is held. k wraps from 63 back to 0 on the exit edge, so it is
  // already 0 when the next sequence starts.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state <= StClear;
      k     <= 6'd0;
      row   <= 2'd0;
      col   <= 4'd0;
    end else begin
      if (memWe) begin
        screenBuf[memAddr] <= memData;
      end
      case (state)
        StClear, StScroll: begin
          k <= k + 6'd1;
          if (k == 6'd63) begin
            state <= StIdle;
          end
        end
        StIdle: begin
          if (clear_i) begin
            row   <= 2'd0;
            col   <= 4'd0;
            k     <= 6'd0;
            state <= StClear;
          end else if (char_valid_i) begin
            if (isPrintable) begin
              if (col == 4'd15) begin
                col <= 4'd0;
                if (row == 2'd3) begin
                  k     <= 6'd0;
                  state <= StScroll;
                end else begin
                  row <= row + 2'd1;
                end
              end else begin
                col <= col + 4'd1;
              end
            end else if (char_i == LineFeed) begin
              col <= 4'd0;
              if (row == 2'd3) begin
                k     <= 6'd0;
                state <= StScroll;
              end else begin
                row <= row + 2'd1;
              end
            end else if (char_i == CarReturn) begin
              col <= 4'd0;
            end else if ((char_i == BackSpace) && (col != 4'd0)) begin
              col <= col - 4'd1;
            end
          end
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

`ifdef TEXT_WRITER_CURSOR_EN
  logic [BLINK_BITS-1:0] blinkCount;

  // The blink counter runs freely from reset. Its MSB drives the cursor
  // overlay. The overlay is only shown while idle, so that CLEAR and SCROLL
  // read back the raw contents.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      blinkCount <= '0;
    end else begin
      blinkCount <= blinkCount + 1'b1;
    end
  end

  assign outByte_o = (blinkCount[BLINK_BITS-1] && (state == StIdle) &&
                      (readAddress_i == cursor_o)) ? 8'h5F : rawByte;
`else
  assign outByte_o = rawByte;
`endif

endmodule

// File: tb/tb_text_writer.sv
// -----------------------------------------------------------------------------
// tb_text_writer
//
// Self-checking bench for text_writer. A behavioural screen model follows
// every accepted byte. Expected cell contents are queued from the model and
// compared against the read port when the DUT is idle.
// -----------------------------------------------------------------------------
module tb_text_writer;

  typedef struct {
    logic [5:0] addr;
    logic [7:0] value;
  } sbEntry_t;

  logic       clk_i;
  logic       reset_ni;
  logic       char_valid_i;
  logic [7:0] char_i;
  logic       char_ready_o;
  logic       clear_i;
  logic [5:0] readAddress_i;
  logic [7:0] outByte_o;
  logic [5:0] cursor_o;
  logic       busy_o;

  int errorCount;
  int checkCount;

  sbEntry_t   sbQueue [$];
  logic [7:0] model [64];
  logic [1:0] mRow;
  logic [3:0] mCol;

  text_writer dut (
    .clk_i        (clk_i),
    .reset_ni     (reset_ni),
    .char_valid_i (char_valid_i),
    .char_i       (char_i),
    .char_ready_o (char_ready_o),
    .clear_i      (clear_i),
    .readAddress_i(readAddress_i),
    .outByte_o    (outByte_o),
    .cursor_o     (cursor_o),
    .busy_o       (busy_o)
  );

  // Free-running clock with a 10-unit period.
  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Safety net in case a sequencing bug stalls the whole run.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  // Counts one comparison and reports it when the values differ.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Resets the model to a blank screen with the cursor at home.
  task automatic modelClear();
    for (int i = 0; i < 64; i++) model[i] = 8'h20;
    mRow = 2'd0;
    mCol = 4'd0;
  endtask

  // Moves model rows 1..3 up one row and blanks the bottom row.
  task automatic modelScroll();
    for (int i = 0; i < 48; i++) model[i] = model[i + 16];
    for (int i = 48; i < 64; i++) model[i] = 8'h20;
  endtask

  // Applies one accepted byte to the model, as terminal behaviour.
  task automatic modelByte(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      model[{mRow, mCol}] = b;
      if (mCol == 4'd15) begin
        mCol = 4'd0;
        if (mRow == 2'd3) modelScroll();
        else mRow = mRow + 2'd1;
      end else begin
        mCol = mCol + 4'd1;
      end
    end else if (b == 8'h0A) begin
      mCol = 4'd0;
      if (mRow == 2'd3) modelScroll();
      else mRow = mRow + 2'd1;
    end else if (b == 8'h0D) begin
      mCol = 4'd0;
    end else if (b == 8'h08 && mCol != 4'd0) begin
      mCol = mCol - 4'd1;
      model[{mRow, mCol}] = 8'h20;
    end
  endtask

  // Queues the model's view of every cell.
  task automatic pushAll();
    sbEntry_t e;
    for (int i = 0; i < 64; i++) begin
      e.addr  = 6'(i);
      e.value = model[i];
      sbQueue.push_back(e);
    end
  endtask

  // Reads each queued cell back through the read port. Call this only while
  // the DUT is idle with no input pending.
  task automatic drainScoreboard();
    sbEntry_t e;
    while (sbQueue.size() > 0) begin
      e = sbQueue.pop_front();
      readAddress_i = e.addr;
      #1;
      checkOutput($sformatf("cell%0d", e.addr), {24'd0, outByte_o},
                  {24'd0, e.value});
    end
    @(negedge clk_i);
  endtask

  // Counts the negedge samples for which char_ready_o stays low.
  task automatic measureReadyLow(output int n);
    n = 0;
    while (!char_ready_o && n < 300) begin
      n++;
      @(negedge clk_i);
    end
  endtask

  // Offers one byte from a negedge and returns on the negedge after the
  // accepting edge. waited counts the stall cycles.
  task automatic applyStimulus(input logic [7:0] b, output int waited);
    char_valid_i = 1'b1;
    char_i       = b;
    waited       = 0;
    while (!char_ready_o && waited < 300) begin
      waited++;
      @(negedge clk_i);
    end
    if (waited >= 300) begin
      checkOutput("acceptTimeout", 32'd0, 32'd1);
      char_valid_i = 1'b0;
    end else begin
      @(negedge clk_i);
      char_valid_i = 1'b0;
      modelByte(b);
    end
  endtask

  // Test sequence.
  initial begin
    int n;
    int w;
    int waitSum;
    logic [7:0] str [4];

    errorCount    = 0;
    checkCount    = 0;
    reset_ni      = 1'b0;
    char_valid_i  = 1'b0;
    char_i        = 8'h00;
    clear_i       = 1'b0;
    readAddress_i = 6'd0;

    // Reset: held low for 3 cycles, then released.
    repeat (2) @(negedge clk_i);
    checkOutput("rstBusy", {31'd0, busy_o}, 32'd1);
    checkOutput("rstReady", {31'd0, char_ready_o}, 32'd0);
    checkOutput("rstCursor", {26'd0, cursor_o}, 32'd0);
    @(negedge clk_i);
    reset_ni = 1'b1;
    measureReadyLow(n);
    checkOutput("rstClearLen", n, 32'd64);
    modelClear();
    pushAll();
    drainScoreboard();
    checkOutput("rstCursorIdle", {26'd0, cursor_o}, 32'd0);

    // "ABC" back-to-back.
    str[0] = 8'h41; str[1] = 8'h42; str[2] = 8'h43;
    waitSum = 0;
    for (int i = 0; i < 3; i++) begin
      applyStimulus(str[i], w);
      waitSum += w;
    end
    checkOutput("abcStall", waitSum, 32'd0);
    checkOutput("abcCursor", {26'd0, cursor_o}, 32'd3);
    pushAll();
    drainScoreboard();

    // CR, then 'H' 'I' BS CR. After that, BS at column 0 and an unused code.
    applyStimulus(8'h0D, w);
    applyStimulus(8'h48, w);
    applyStimulus(8'h49, w);
    applyStimulus(8'h08, w);
    checkOutput("bsCursor", {26'd0, cursor_o}, 32'd1);
    readAddress_i = 6'd1;
    #1;
    checkOutput("bsCell1", {24'd0, outByte_o}, 32'h20);
    applyStimulus(8'h0D, w);
    checkOutput("crCursor", {26'd0, cursor_o}, 32'd0);
    applyStimulus(8'h08, w);
    applyStimulus(8'h07, w);
    checkOutput("bsCol0Cursor", {26'd0, cursor_o}, 32'd0);
    pushAll();
    drainScoreboard();

    // Fill 64 printable bytes from home. The 64th byte triggers a scroll.
    waitSum = 0;
    for (int i = 0; i < 64; i++) begin
      applyStimulus(8'h30 + 8'(i), w);
      waitSum += w;
    end
    checkOutput("fillStall", waitSum, 32'd0);
    measureReadyLow(n);
    checkOutput("scrollLen", n, 32'd64);
    checkOutput("scrollCursor", {26'd0, cursor_o}, 32'd48);
    readAddress_i = 6'd0;
    #1;
    checkOutput("scrollCell0", {24'd0, outByte_o}, 32'h40);
    readAddress_i = 6'd47;
    #1;
    checkOutput("scrollCell47", {24'd0, outByte_o}, 32'h6F);
    pushAll();
    drainScoreboard();

    // clear_i and a valid byte together in IDLE: the clear wins.
    clear_i      = 1'b1;
    char_valid_i = 1'b1;
    char_i       = 8'h41;
    #1;
    checkOutput("clrReady", {31'd0, char_ready_o}, 32'd0);
    @(negedge clk_i);
    clear_i = 1'b0;
    modelClear();
    measureReadyLow(n);
    checkOutput("clrLen", n, 32'd64);
    @(negedge clk_i);
    char_valid_i = 1'b0;
    modelByte(8'h41);
    checkOutput("clrPendCursor", {26'd0, cursor_o}, 32'd1);
    readAddress_i = 6'd0;
    #1;
    checkOutput("clrPendCell0", {24'd0, outByte_o}, 32'h41);
    pushAll();
    drainScoreboard();

    // Start a scroll with line feeds, then reset at k = 20.
    for (int i = 0; i < 4; i++) applyStimulus(8'h0A, w);
    repeat (20) @(negedge clk_i);
    checkOutput("midScrollBusy", {31'd0, busy_o}, 32'd1);
    reset_ni = 1'b0;
    #1;
    checkOutput("midRstBusy", {31'd0, busy_o}, 32'd1);
    checkOutput("midRstCursor", {26'd0, cursor_o}, 32'd0);
    repeat (2) @(negedge clk_i);
    reset_ni = 1'b1;
    measureReadyLow(n);
    checkOutput("midRstClearLen", n, 32'd64);
    modelClear();
    pushAll();
    drainScoreboard();
    checkOutput("midRstCursorIdle", {26'd0, cursor_o}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
